caliptra_prim_fifo_async_wr_packer: RTL and testbench
=====================================================

CALIPTRA_PRIM_FIFO_ASYNC_WR_PACKER -- requirements
Module: caliptra_prim_fifo_async_wr_packer

Interface
REQ-001 SHALL have parameter InW, default 8: input chunk width in bits.
REQ-002 SHALL have parameter OutW, default 32: packed word width; legal only when OutW is a multiple of InW and OutW/InW is a power of 2 and at least 2 (init-time assertion).
REQ-003 SHALL have parameter FifoDepthW, default 3: width of the downstream FIFO depth input.
REQ-004 SHALL have parameter AFullThr, default 3: almost-full threshold, in FIFO entries.
REQ-005 SHALL define derived value R = OutW/InW, with chunk count width CntW = $clog2(R+1).
REQ-006 SHALL have port clk_wr_i, input, 1 bit: write-domain clock.
REQ-007 SHALL have port rst_wr_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid_i, input, 1 bit: input chunk valid.
REQ-009 SHALL have port in_ready_o, output, 1 bit: input chunk accepted when high together with in_valid_i.
REQ-010 SHALL have port in_data_i, input, InW bits: input chunk data.
REQ-011 SHALL have port in_last_i, input, 1 bit: chunk ends the current message.
REQ-012 SHALL have port flush_i, input, 1 bit: single-cycle request to emit any partial word.
REQ-013 SHALL have port out_valid_o, output, 1 bit: drives the FIFO wvalid.
REQ-014 SHALL have port out_ready_i, input, 1 bit: driven by the FIFO wready.
REQ-015 SHALL have port out_data_o, output, OutW bits: packed word, chunk 0 in the LSBs.
REQ-016 SHALL have port out_nchunks_o, output, CntW bits: number of valid chunks in the word, 1..R.
REQ-017 SHALL have port out_last_o, output, 1 bit: word closes a message.
REQ-018 SHALL have port wdepth_i, input, FifoDepthW bits: FIFO write-side fill level.
REQ-019 SHALL have port almost_full_o, output, 1 bit: registered almost-full flag.
REQ-020 SHALL have port word_cnt_o, output, 16 bits: count of words pushed to the FIFO, wrapping.

Function
REQ-021 SHALL hold state in an accumulator acc_q (OutW bits), a chunk counter cnt_q (0..R-1), and an output holding register (data, nchunks, last, valid).
REQ-022 in_ready_o SHALL equal !out_valid_o || out_ready_i; there is no combinational path from in_valid_i to in_ready_o.
REQ-023 On an accept (in_valid_i && in_ready_o), chunk in_data_i SHALL be placed at bits [cnt_q*InW +: InW].
REQ-024 An accept SHALL complete a word when cnt_q==R-1, when in_last_i=1, or when flush_i=1 in the same cycle.
REQ-025 On a completing accept, the holding register SHALL be loaded next cycle as follows:
- data = acc_q merged with the current chunk, all unfilled upper chunks zero;
- nchunks = cnt_q+1;
- last = in_last_i.
REQ-026 On a completing accept, acc_q and cnt_q SHALL clear to 0.
REQ-027 A non-completing accept SHALL increment cnt_q by 1; the holding register SHALL be unchanged unless it is drained.
REQ-028 On flush_i=1 with no accept, cnt_q>0, and the holding register free (!out_valid_o || out_ready_i), the partial word SHALL be emitted with nchunks=cnt_q and last=0, then acc_q and cnt_q SHALL clear.
REQ-029 A flush_i that cannot be serviced in its cycle (cnt_q==0, or holding register busy) SHALL be dropped, not queued.
REQ-030 out_valid_o SHALL set on a load and clear on (out_valid_o && out_ready_i) with no new load; drain and load in the same cycle SHALL keep out_valid_o=1 with the new contents.
REQ-031 While out_valid_o=1 && out_ready_i=0, out_data_o, out_nchunks_o and out_last_o SHALL remain stable.
REQ-032 Latency SHALL be 1 cycle from the completing accept to out_valid_o=1; sustained throughput SHALL be 1 chunk per cycle when out_ready_i=1.
REQ-033 word_cnt_o SHALL increment by 1 per out_valid_o && out_ready_i cycle and wrap from 0xFFFF to 0.
REQ-034 almost_full_o SHALL be registered as (wdepth_i >= AFullThr), compared at FifoDepthW width; it is advisory only and SHALL NOT gate any handshake.
REQ-035 out_data_o, out_nchunks_o and out_last_o SHALL be driven to zero whenever out_valid_o=0.

Reset
REQ-036 On rst_wr_ni=0, asynchronously:
- acc_q=0 and cnt_q=0;
- out_valid_o=0, out_data_o=0, out_nchunks_o=0, out_last_o=0;
- almost_full_o=0 and word_cnt_o=0.
REQ-037 Reset asserted mid-word SHALL discard partial chunks and the held word; the first accept after reset SHALL land in chunk 0.
REQ-038 in_ready_o SHALL be 1 during and immediately after reset.

Verification
REQ-039 InW=8, OutW=32; bytes 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready_i=1 -> one word 0x44332211, nchunks=4, last=0, exactly 1 cycle after the 4th accept.
REQ-040 Bytes 0xAA,0xBB with in_last_i on 0xBB -> out_data_o=0x0000BBAA, nchunks=2, last=1, cnt_q back to 0.
REQ-041 out_ready_i=0 while 8 bytes are offered -> 1st word held stable, in_ready_o=0 after the 4th accept; after out_ready_i=1 both words emerge in order with no loss or duplication; word_cnt_o=2.
REQ-042 3 bytes 0x01,0x02,0x03, then flush_i pulse -> 0x00030201, nchunks=3, last=0; a flush_i pulse with cnt_q=0 -> no output.
REQ-043 Reset asserted after 2 bytes, then 4 new bytes -> single word of only the new bytes; word_cnt_o=1.
REQ-044 wdepth_i stepped 2->3->2 with AFullThr=3 -> almost_full_o goes 0, 1, 0, each 1 cycle delayed.

Source files
------------

// File: rtl/caliptra_prim_fifo_async_wr_packer.sv
// Packs InW-bit chunks into OutW-bit words (chunk 0 in the LSBs) ahead of an async FIFO write port.
// One-entry output holding register with valid/ready handshake, flush and message-last support.
module caliptra_prim_fifo_async_wr_packer #(
    parameter int unsigned InW        = 8,
    parameter int unsigned OutW       = 32,
    parameter int unsigned FifoDepthW = 3,
    parameter int unsigned AFullThr   = 3,
    localparam int unsigned R         = OutW / InW,
    localparam int unsigned CntW      = $clog2(R + 1)
) (
    input  logic                  clk_wr_i,
    input  logic                  rst_wr_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [InW-1:0]        in_data_i,
    input  logic                  in_last_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OutW-1:0]       out_data_o,
    output logic [CntW-1:0]       out_nchunks_o,
    output logic                  out_last_o,
    input  logic [FifoDepthW-1:0] wdepth_i,
    output logic                  almost_full_o,
    output logic [15:0]           word_cnt_o
);

    if ((OutW % InW) != 0 || R < 2 || (R & (R - 1)) != 0) begin : gen_bad_params
        $error("OutW must be InW times a power of two >= 2");
    end

    logic [OutW-1:0] acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [OutW-1:0] out_data_q, out_data_d;
    logic [CntW-1:0] out_nchunks_q, out_nchunks_d;
    logic            out_last_q, out_last_d;
    logic            out_valid_q, out_valid_d;
    logic            almost_full_q;
    logic [15:0]     word_cnt_q;

    logic            accept, complete, flush_emit, drain, load;
    logic [OutW-1:0] merged;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign complete   = accept && (cnt_q == CntW'(R - 1) || in_last_i || flush_i);
    assign flush_emit = flush_i && !accept && (cnt_q != '0) && in_ready_o;
    assign drain      = out_valid_q && out_ready_i;
    assign load       = complete || flush_emit;

    // Upper chunks of acc_q are always zero, so only the current slot needs writing.
    always_comb begin
        merged = acc_q;
        for (int unsigned i = 0; i < R; i++) begin
            if (cnt_q == CntW'(i)) begin
                merged[i*InW +: InW] = in_data_i;
            end
        end
    end

    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_nchunks_d = out_nchunks_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;
        if (load) begin
            acc_d         = '0;
            cnt_d         = '0;
            out_valid_d   = 1'b1;
            out_data_d    = complete ? merged : acc_q;
            out_nchunks_d = complete ? cnt_q + CntW'(1) : cnt_q;
            out_last_d    = complete && in_last_i;
        end else begin
            if (accept) begin
                acc_d = merged;
                cnt_d = cnt_q + CntW'(1);
            end
            if (drain) begin
                out_valid_d   = 1'b0;
                out_data_d    = '0;
                out_nchunks_d = '0;
                out_last_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
        if (!rst_wr_ni) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_nchunks_q <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_nchunks_q <= out_nchunks_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= (wdepth_i >= FifoDepthW'(AFullThr));
            if (drain) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_nchunks_o = out_nchunks_q;
    assign out_last_o    = out_last_q;
    assign almost_full_o = almost_full_q;
    assign word_cnt_o    = word_cnt_q;

endmodule

// File: tb/tb_caliptra_prim_fifo_async_wr_packer.sv
// Directed bench for the write-side packer; a queue of expected words is checked at each handshake.
module tb_caliptra_prim_fifo_async_wr_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0, flush = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_valid, out_ready = 1'b1, out_last;
    logic [31:0] out_data;
    logic [2:0]  out_nchunks;
    logic [2:0]  wdepth = '0;
    logic        almost_full;
    logic [15:0] word_cnt;

    int total = 0;
    int bad = 0;
    int exp_words = 0;
    logic [35:0] expq[$];

    always #5 clk = ~clk;

    caliptra_prim_fifo_async_wr_packer #(
        .InW(8), .OutW(32), .FifoDepthW(3), .AFullThr(3)
    ) dut (
        .clk_wr_i      (clk),
        .rst_wr_ni     (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .in_last_i     (in_last),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_nchunks_o (out_nchunks),
        .out_last_o    (out_last),
        .wdepth_i      (wdepth),
        .almost_full_o (almost_full),
        .word_cnt_o    (word_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] n, input logic l);
        expq.push_back({d, n, l});
        exp_words++;
    endtask

    // Monitor: pops one expected word on each handshake; checks idle outputs are zero.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_word", {32'd0, out_data}, 64'hDEAD);
            end else begin
                logic [35:0] e;
                e = expq.pop_front();
                chk("word_data", {32'd0, out_data}, {32'd0, e[35:4]});
                chk("word_nchunks", {61'd0, out_nchunks}, {61'd0, e[3:1]});
                chk("word_last", {63'd0, out_last}, {63'd0, e[0]});
            end
        end else if (!out_valid) begin
            chk("idle_zero", {28'd0, out_data, out_nchunks, out_last}, 64'd0);
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic f);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        flush    = f;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 30 && (expq.size() != 0 || out_valid); n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", {63'd0, out_valid}, 64'd0);
        chk("word_cnt", {48'd0, word_cnt}, 64'(exp_words % 65536));
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_wcnt", {48'd0, word_cnt}, 64'd0);
        chk("rst_af", {63'd0, almost_full}, 64'd0);
        expq.delete();
        exp_words = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        do_reset();

        // Full word, back-to-back, 1-cycle latency
        send(8'h11, 0, 0);
        send(8'h22, 0, 0);
        send(8'h33, 0, 0);
        chk("no_early_valid", {63'd0, out_valid}, 64'd0);
        push(32'h44332211, 3'd4, 1'b0);
        send(8'h44, 0, 0);
        chk("latency_1", {63'd0, out_valid}, 64'd1);
        wait_drain();

        // Short message closed by in_last
        send(8'hAA, 0, 0);
        push(32'h0000BBAA, 3'd2, 1'b1);
        send(8'hBB, 1, 0);
        wait_drain();

        // Backpressure: holding word stays stable, input stalls
        do_reset();
        out_ready = 1'b0;
        send(8'h01, 0, 0);
        send(8'h02, 0, 0);
        send(8'h03, 0, 0);
        push(32'h04030201, 3'd4, 1'b0);
        send(8'h04, 0, 0);
        chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_stable", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h04030201});
        end
        out_ready = 1'b1;
        send(8'h05, 0, 0);
        send(8'h06, 0, 0);
        send(8'h07, 0, 0);
        push(32'h08070605, 3'd4, 1'b0);
        send(8'h08, 0, 0);
        wait_drain();
        chk("bp_wcnt2", {48'd0, word_cnt}, 64'd2);

        // Flush of a partial word, then a flush with nothing pending
        send(8'h01, 0, 0);
        send(8'h02, 0, 0);
        send(8'h03, 0, 0);
        push(32'h00030201, 3'd3, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd1);
        wait_drain();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("empty_flush", {63'd0, out_valid}, 64'd0);
        end
        wait_drain();

        // Reset mid-word discards partial chunks
        send(8'hAA, 0, 0);
        send(8'hBB, 0, 0);
        do_reset();
        send(8'h11, 0, 0);
        send(8'h22, 0, 0);
        send(8'h33, 0, 0);
        push(32'h44332211, 3'd4, 1'b0);
        send(8'h44, 0, 0);
        wait_drain();
        chk("rst_wcnt1", {48'd0, word_cnt}, 64'd1);

        // Almost-full is a registered compare
        wdepth = 3'd2;
        @(posedge clk);
        #1;
        chk("af_2", {63'd0, almost_full}, 64'd0);
        wdepth = 3'd3;
        chk("af_3_delay", {63'd0, almost_full}, 64'd0);
        @(posedge clk);
        #1;
        chk("af_3", {63'd0, almost_full}, 64'd1);
        wdepth = 3'd2;
        chk("af_2_delay", {63'd0, almost_full}, 64'd1);
        @(posedge clk);
        #1;
        chk("af_back", {63'd0, almost_full}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
